// File: rtl/imm_extend_stage.sv
// rtl/imm_extend_stage.sv - per-lane immediate extension with main + skid output buffering
// Optional feature macro: IMM_EXTEND_ROT_EN (ImmSrc 11 becomes a rotate-immediate mode).
module imm_extend_stage #(
  parameter int LANES = 2,
  parameter int D_WIDTH = 32
) (
  input  logic                     i_clk,
  input  logic                     i_rst_n,
  input  logic                     i_flush,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [LANES*24-1:0]      i_imm,
  input  logic [LANES*2-1:0]       i_src,
  input  logic [LANES-1:0]         i_lane_vld,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [LANES*D_WIDTH-1:0] o_ext,
  output logic [LANES-1:0]         o_lane_vld,
  output logic                     o_bad_src
);

  // Extend one raw 24-bit immediate according to its ImmSrc selector.
  function automatic logic [D_WIDTH-1:0] extend_imm(input logic [23:0] imm,
                                                    input logic [1:0]  src);
    logic [D_WIDTH-1:0] res;
`ifdef IMM_EXTEND_ROT_EN
    logic [63:0] dbl;
    logic [4:0]  sh;
`endif
    res = '0;
    case (src)
      2'b00:   res = D_WIDTH'($signed(imm[7:0]));
      2'b01:   res = D_WIDTH'(imm[11:0]);
      2'b10:   res = D_WIDTH'($signed(imm[23:0]));
      default: begin
`ifdef IMM_EXTEND_ROT_EN
        // Rotate within 32 bits by shifting a doubled copy; the low word is the result.
        sh  = {imm[11:8], 1'b0};
        dbl = {24'd0, imm[7:0], 24'd0, imm[7:0]} >> sh;
        res = D_WIDTH'(dbl[31:0]);
`else
        res = '0;
`endif
      end
    endcase
    return res;
  endfunction

  // True when a valid lane uses a selector this build does not implement.
  function automatic logic is_bad_src(input logic [1:0] src, input logic vld);
`ifdef IMM_EXTEND_ROT_EN
    return 1'b0 & vld & src[0];
`else
    return vld & (src == 2'b11);
`endif
  endfunction

  logic [LANES*D_WIDTH-1:0] in_ext;
  logic [LANES-1:0]         in_bad;

  genvar k;
  generate
    for (k = 0; k < LANES; k++) begin : g_lane
      // Per-lane extension; invalid lanes are forced to zero before storage.
      always_comb begin
        in_ext[D_WIDTH*k +: D_WIDTH] = '0;
        if (i_lane_vld[k]) begin
          in_ext[D_WIDTH*k +: D_WIDTH] = extend_imm(i_imm[24*k +: 24], i_src[2*k +: 2]);
        end
        in_bad[k] = is_bad_src(i_src[2*k +: 2], i_lane_vld[k]);
      end
    end
  endgenerate

  logic                     main_valid, main_valid_nxt;
  logic [LANES*D_WIDTH-1:0] main_ext, main_ext_nxt;
  logic [LANES-1:0]         main_lv, main_lv_nxt;
  logic                     skid_valid, skid_valid_nxt;
  logic [LANES*D_WIDTH-1:0] skid_ext, skid_ext_nxt;
  logic [LANES-1:0]         skid_lv, skid_lv_nxt;
  logic                     ready_q;
  logic                     bad_q, bad_nxt;
  logic                     in_fire, out_fire;

  assign in_fire    = i_valid && ready_q;
  assign out_fire   = main_valid && i_ready;
  assign o_ready    = ready_q;
  assign o_valid    = main_valid;
  assign o_ext      = main_ext;
  assign o_lane_vld = main_lv;
  assign o_bad_src  = bad_q;

  // Next-state for main/skid: skid always drains into main before new input lands.
  // Skid full and in_fire never coincide because ready_q mirrors an empty skid.
  always_comb begin
    main_valid_nxt = main_valid;
    main_ext_nxt   = main_ext;
    main_lv_nxt    = main_lv;
    skid_valid_nxt = skid_valid;
    skid_ext_nxt   = skid_ext;
    skid_lv_nxt    = skid_lv;
    if (i_flush) begin
      main_valid_nxt = 1'b0;
      skid_valid_nxt = 1'b0;
    end else if (out_fire) begin
      if (skid_valid) begin
        main_ext_nxt   = skid_ext;
        main_lv_nxt    = skid_lv;
        skid_valid_nxt = 1'b0;
      end else if (in_fire) begin
        main_ext_nxt   = in_ext;
        main_lv_nxt    = i_lane_vld;
      end else begin
        main_valid_nxt = 1'b0;
      end
    end else if (in_fire) begin
      if (main_valid) begin
        skid_valid_nxt = 1'b1;
        skid_ext_nxt   = in_ext;
        skid_lv_nxt    = i_lane_vld;
      end else begin
        main_valid_nxt = 1'b1;
        main_ext_nxt   = in_ext;
        main_lv_nxt    = i_lane_vld;
      end
    end
  end

  // Sticky unsupported-selector flag, set only by an accepted bundle.
  always_comb begin
    bad_nxt = bad_q | (in_fire & ~i_flush & (|in_bad));
  end

  // State registers; ready is registered as the complement of the next skid state.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      main_valid <= 1'b0;
      main_ext   <= '0;
      main_lv    <= '0;
      skid_valid <= 1'b0;
      skid_ext   <= '0;
      skid_lv    <= '0;
      ready_q    <= 1'b1;
      bad_q      <= 1'b0;
    end else begin
      main_valid <= main_valid_nxt;
      main_ext   <= main_ext_nxt;
      main_lv    <= main_lv_nxt;
      skid_valid <= skid_valid_nxt;
      skid_ext   <= skid_ext_nxt;
      skid_lv    <= skid_lv_nxt;
      ready_q    <= ~skid_valid_nxt;
      bad_q      <= bad_nxt;
    end
  end

endmodule
